// File: rtl/comparator_pkg.sv
// Shared types and helpers for the comparator family: default width,
// the compact 2-bit compare verdict and its one-hot flag expansion.
package comparator_pkg;

    localparam int CMP_DEFAULT_WIDTH = 4;

    // Compact verdict of a single compare; exactly one outcome is ever true.
    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_LT = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    // Expand a verdict into the {eq, lt, gt} one-hot flag vector.
    // The unused code maps to all-zero so a corrupted code never
    // produces a plausible-looking flag pattern.
    function automatic logic [2:0] cmp_encode(input cmp_result_t res);
        logic [2:0] flags;
        case (res)
            CMP_EQ:  flags = 3'b100;
            CMP_LT:  flags = 3'b010;
            CMP_GT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/comparator_4_cmp_bit_slice.sv
// One bit of an MSB-first magnitude compare chain. The upstream inputs
// carry the verdict of all more-significant bits; once a higher bit has
// decided lt/gt, this bit only passes that verdict along.
module cmp_bit_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic eq_i,
    input  logic lt_i,
    input  logic gt_i,
    output logic eq_o,
    output logic lt_o,
    output logic gt_o
);

    // Combine the local bit comparison with the verdict from higher bits.
    always_comb begin
        eq_o = eq_i & (a_i ~^ b_i);
        lt_o = lt_i | (eq_i & ~a_i & b_i);
        gt_o = gt_i | (eq_i & a_i & ~b_i);
    end

endmodule

// File: rtl/comparator_4.sv
// Registered equality/magnitude comparator. A chain of bit slices
// produces the unsigned verdict, a sign fix-up corrects it for
// two's-complement operands, and a single register stage presents the
// one-hot eq/lt/gt flags one cycle after a valid sample.
module comparator_4
    import comparator_pkg::*;
#(
    parameter int WIDTH      = CMP_DEFAULT_WIDTH,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic             out_valid,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    // Chain index WIDTH is the seed ("all higher bits equal"); slice g
    // consumes index g+1 and drives index g, so index 0 is the verdict.
    logic [WIDTH:0] eq_chain_s;
    logic [WIDTH:0] lt_chain_s;
    logic [WIDTH:0] gt_chain_s;

    assign eq_chain_s[WIDTH] = 1'b1;
    assign lt_chain_s[WIDTH] = 1'b0;
    assign gt_chain_s[WIDTH] = 1'b0;

    for (genvar g = 0; g < WIDTH; g++) begin : g_slice
        cmp_bit_slice u_slice (
            .a_i  (i0[g]),
            .b_i  (i1[g]),
            .eq_i (eq_chain_s[g+1]),
            .lt_i (lt_chain_s[g+1]),
            .gt_i (gt_chain_s[g+1]),
            .eq_o (eq_chain_s[g]),
            .lt_o (lt_chain_s[g]),
            .gt_o (gt_chain_s[g])
        );
    end

    logic        msb_diff_s;
    logic        lt_fix_s;
    logic        gt_fix_s;
    cmp_result_t res_s;
    logic [2:0]  flags_s;

    assign msb_diff_s = i0[WIDTH-1] ^ i1[WIDTH-1];

    // Signed fix-up: when the sign bits differ the unsigned chain has
    // decided on the MSB with the opposite sense, so lt and gt swap.
    always_comb begin
        lt_fix_s = lt_chain_s[0];
        gt_fix_s = gt_chain_s[0];
        if (SIGNED_CMP && msb_diff_s) begin
            lt_fix_s = gt_chain_s[0];
            gt_fix_s = lt_chain_s[0];
        end else begin
            lt_fix_s = lt_chain_s[0];
            gt_fix_s = gt_chain_s[0];
        end
    end

    // Collapse the flags into a single verdict so the registered result
    // is one-hot by construction.
    always_comb begin
        res_s = CMP_EQ;
        if (eq_chain_s[0]) begin
            res_s = CMP_EQ;
        end else if (lt_fix_s) begin
            res_s = CMP_LT;
        end else if (gt_fix_s) begin
            res_s = CMP_GT;
        end else begin
            res_s = CMP_EQ;
        end
    end

    assign flags_s = cmp_encode(res_s);

    logic       out_valid_q;
    logic       out_valid_d;
    logic [2:0] flags_q;
    logic [2:0] flags_d;

    // Next-state: capture a new verdict on valid input, otherwise hold
    // the flags and drop the valid strobe.
    always_comb begin
        out_valid_d = 1'b0;
        flags_d     = flags_q;
        if (in_valid) begin
            out_valid_d = 1'b1;
            flags_d     = flags_s;
        end else begin
            out_valid_d = 1'b0;
            flags_d     = flags_q;
        end
    end

    // Output register; reset wins over a sample on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            flags_q     <= 3'b000;
        end else begin
            out_valid_q <= out_valid_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign eq        = flags_q[2];
    assign lt        = flags_q[1];
    assign gt        = flags_q[0];

endmodule

// File: tb/tb_comparator_4.sv
// Self-checking bench for comparator_4: unsigned and signed 4-bit
// instances plus a 1-bit signed instance share one stimulus stream and
// are checked against an integer-arithmetic reference model.
module tb_comparator_4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] i0;
    logic [3:0] i1;

    logic ov_u, eq_u, lt_u, gt_u;
    logic ov_s, eq_s, lt_s, gt_s;
    logic ov_1, eq_1, lt_1, gt_1;

    int checks = 0;
    int errors = 0;

    // Expected {valid, eq, lt, gt} for each instance.
    logic [3:0] exp_u = 4'b0000;
    logic [3:0] exp_s = 4'b0000;
    logic [3:0] exp_1 = 4'b0000;

    always #5 clk = ~clk;

    comparator_4 #(.WIDTH(4), .SIGNED_CMP(1'b0)) u_dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i0(i0), .i1(i1),
        .out_valid(ov_u), .eq(eq_u), .lt(lt_u), .gt(gt_u));

    comparator_4 #(.WIDTH(4), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i0(i0), .i1(i1),
        .out_valid(ov_s), .eq(eq_s), .lt(lt_s), .gt(gt_s));

    comparator_4 #(.WIDTH(1), .SIGNED_CMP(1'b1)) u_dut_1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .i0(i0[0]), .i1(i1[0]),
        .out_valid(ov_1), .eq(eq_1), .lt(lt_1), .gt(gt_1));

    task automatic check_result(input string tag, input logic [3:0] got,
                                input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b (rst=%b v=%b i0=%h i1=%h)",
                     tag, got, exp, rst, in_valid, i0, i1);
        end
    endtask

    // Reference: interpret operands as integers and compare arithmetically.
    function automatic logic [2:0] ref_flags(input int a, input int b,
                                              input int width, input bit sgn);
        int sa, sb;
        sa = a;
        sb = b;
        if (sgn && a >= (1 << (width - 1))) sa = a - (1 << width);
        if (sgn && b >= (1 << (width - 1))) sb = b - (1 << width);
        return {sa == sb, sa < sb, sa > sb};
    endfunction

    function automatic logic [3:0] ref_next(input logic [3:0] prev, input int a,
                                             input int b, input int width,
                                             input bit sgn);
        if (rst) return 4'b0000;
        if (in_valid) return {1'b1, ref_flags(a, b, width, sgn)};
        return {1'b0, prev[2:0]};
    endfunction

    // Apply one cycle of stimulus, advance the model, and check all DUTs.
    task automatic step(input logic r, input logic v, input logic [3:0] a,
                        input logic [3:0] b);
        rst      = r;
        in_valid = v;
        i0       = a;
        i1       = b;
        exp_u = ref_next(exp_u, int'(a), int'(b), 4, 1'b0);
        exp_s = ref_next(exp_s, int'(a), int'(b), 4, 1'b1);
        exp_1 = ref_next(exp_1, int'(a[0]), int'(b[0]), 1, 1'b1);
        @(posedge clk);
        #1;
        check_result("unsigned4", {ov_u, eq_u, lt_u, gt_u}, exp_u);
        check_result("signed4",   {ov_s, eq_s, lt_s, gt_s}, exp_s);
        check_result("signed1",   {ov_1, eq_1, lt_1, gt_1}, exp_1);
        if (ov_u) check_result("onehot_u", 4'(eq_u + lt_u + gt_u), 4'd1);
        if (ov_s) check_result("onehot_s", 4'(eq_s + lt_s + gt_s), 4'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; i0 = 4'b0000; i1 = 4'b0000;

        // Reset held with a valid sample present: nothing may come out.
        step(1'b1, 1'b1, 4'b1010, 4'b1010);
        step(1'b1, 1'b1, 4'b1010, 4'b1010);
        check_result("reset_state", {ov_u, eq_u, lt_u, gt_u}, 4'b0000);

        // Equal zeros, equal ones, then a mismatch back-to-back.
        step(1'b0, 1'b1, 4'b0000, 4'b0000);
        check_result("eq_zeros", {ov_u, eq_u, lt_u, gt_u}, 4'b1100);
        step(1'b0, 1'b1, 4'b1111, 4'b1111);
        check_result("eq_ones", {ov_u, eq_u, lt_u, gt_u}, 4'b1100);
        step(1'b0, 1'b1, 4'b1111, 4'b1101);
        check_result("mismatch_gt", {ov_u, eq_u, lt_u, gt_u}, 4'b1001);

        // Hold: eq=1 result, then idle with changed i1.
        step(1'b0, 1'b1, 4'b0101, 4'b0101);
        step(1'b0, 1'b0, 4'b0101, 4'b0001);
        check_result("hold_eq", {ov_u, eq_u, lt_u, gt_u}, 4'b0100);
        step(1'b0, 1'b0, 4'b0101, 4'b0001);

        // Sign sensitivity: -8 vs 7, and most-negative vs most-positive.
        step(1'b0, 1'b1, 4'b1000, 4'b0111);
        check_result("uns_8_vs_7", {ov_u, eq_u, lt_u, gt_u}, 4'b1001);
        check_result("sgn_m8_vs_7", {ov_s, eq_s, lt_s, gt_s}, 4'b1010);

        // Exhaustive back-to-back sweep of all operand pairs.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(1'b0, 1'b1, 4'(a), 4'(b));
            end
        end

        // Random traffic with gaps and occasional mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
